// File: rtl/opcode_err_pkg.sv
// Shared types, thresholds and the opcode classifier for the opcode error collector.
package opcode_err_pkg;

  typedef enum logic [1:0] {
    TYPE_LOW   = 2'd0,
    TYPE_HIGH  = 2'd1,
    TYPE_RANGE = 2'd2
  } err_type_e;

  localparam int unsigned OPC_HIGH_TH  = 32;
  localparam int unsigned OPC_RANGE_TH = 64;

  // The opcode is zero-extended to 32 bits so one classifier serves any OPW.
  function automatic err_type_e classify_opcode(input logic [31:0] opc);
    if (opc >= OPC_RANGE_TH) begin
      return TYPE_RANGE;
    end else if (opc >= OPC_HIGH_TH) begin
      return TYPE_HIGH;
    end else begin
      return TYPE_LOW;
    end
  endfunction

endpackage

// File: rtl/opcode_err_fifo.sv
// Report FIFO: power-of-two depth, wrapping pointers plus a separate occupancy count.
module opcode_err_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rdPtr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = (wrPtr_q == AW'(DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
    end
    if (doPop) begin
      rdPtr_d = (rdPtr_q == AW'(DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/opcode_error_collector.sv
// Stages failing opcode checks, classifies them and queues reports for a consumer.
// Optional per-type push counters are enabled with macro OPCODE_ERR_STATS_EN.
module opcode_error_collector
  import opcode_err_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OPW   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           chk_valid,
  input  logic           chk_cond,
  input  logic [OPW-1:0] chk_opcode,
  input  logic           flush,
  output logic           rpt_valid,
  input  logic           rpt_ready,
  output logic [1:0]     rpt_type,
  output logic [OPW-1:0] rpt_opcode,
  output logic [7:0]     drop_cnt
`ifdef OPCODE_ERR_STATS_EN
  ,
  output logic [15:0]    type_cnt0,
  output logic [15:0]    type_cnt1,
  output logic [15:0]    type_cnt2
`endif
);

  logic           pendValid_q, pendValid_d;
  err_type_e      pendType_q, pendType_d;
  logic [OPW-1:0] pendOpc_q, pendOpc_d;
  logic [7:0]     dropCnt_q, dropCnt_d;

  logic           pushReq, pushAccept, dropEvent, popHead;
  logic           fifoFull, fifoEmpty;
  logic [OPW+1:0] headData;

  assign pendValid_d = chk_valid && !chk_cond;
  assign pendType_d  = classify_opcode(32'(chk_opcode));
  assign pendOpc_d   = chk_opcode;

  // Flush only ever kills the report already pending, never the one being staged.
  assign pushReq    = pendValid_q && !flush;
  assign popHead    = rpt_valid && rpt_ready;
  assign pushAccept = pushReq && (!fifoFull || popHead);
  assign dropEvent  = pushReq && fifoFull && !popHead;

  assign dropCnt_d = (dropEvent && (dropCnt_q != 8'hFF)) ? dropCnt_q + 8'd1 : dropCnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pendValid_q <= 1'b0;
      pendType_q  <= TYPE_LOW;
      pendOpc_q   <= '0;
      dropCnt_q   <= '0;
    end else begin
      pendValid_q <= pendValid_d;
      pendType_q  <= pendType_d;
      pendOpc_q   <= pendOpc_d;
      dropCnt_q   <= dropCnt_d;
    end
  end

  opcode_err_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OPW + 2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pushAccept),
    .pop_i   (popHead),
    .wdata_i ({pendType_q, pendOpc_q}),
    .rdata_o (headData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Head fields read as zero whenever nothing is queued.
  assign rpt_valid  = !fifoEmpty;
  assign rpt_type   = rpt_valid ? headData[OPW+1:OPW] : 2'd0;
  assign rpt_opcode = rpt_valid ? headData[OPW-1:0] : '0;
  assign drop_cnt   = dropCnt_q;

`ifdef OPCODE_ERR_STATS_EN
  logic [15:0] typeCnt0_q, typeCnt1_q, typeCnt2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      typeCnt0_q <= '0;
      typeCnt1_q <= '0;
      typeCnt2_q <= '0;
    end else if (pushAccept) begin
      if ((pendType_q == TYPE_LOW) && (typeCnt0_q != 16'hFFFF)) typeCnt0_q <= typeCnt0_q + 16'd1;
      if ((pendType_q == TYPE_HIGH) && (typeCnt1_q != 16'hFFFF)) typeCnt1_q <= typeCnt1_q + 16'd1;
      if ((pendType_q == TYPE_RANGE) && (typeCnt2_q != 16'hFFFF)) typeCnt2_q <= typeCnt2_q + 16'd1;
    end
  end

  assign type_cnt0 = typeCnt0_q;
  assign type_cnt1 = typeCnt1_q;
  assign type_cnt2 = typeCnt2_q;
`endif

endmodule

// File: tb/tb_opcode_error_collector.sv
// Directed bench for opcode_error_collector: expected reports queued at stimulus, popped on handshake.
module tb_opcode_error_collector;

  localparam int OPW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           chk_valid, chk_cond, flush, rpt_ready;
  logic [OPW-1:0] chk_opcode;
  logic           rpt_valid;
  logic [1:0]     rpt_type;
  logic [OPW-1:0] rpt_opcode;
  logic [7:0]     drop_cnt;
`ifdef OPCODE_ERR_STATS_EN
  logic [15:0]    type_cnt0, type_cnt1, type_cnt2;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [OPW+1:0] sb[$];

  opcode_error_collector #(.DEPTH(4), .OPW(OPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .chk_valid  (chk_valid),
    .chk_cond   (chk_cond),
    .chk_opcode (chk_opcode),
    .flush      (flush),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_type   (rpt_type),
    .rpt_opcode (rpt_opcode),
    .drop_cnt   (drop_cnt)
`ifdef OPCODE_ERR_STATS_EN
    ,
    .type_cnt0  (type_cnt0),
    .type_cnt1  (type_cnt1),
    .type_cnt2  (type_cnt2)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] expType(input logic [OPW-1:0] opc);
    if (opc >= 8'd64) return 2'd2;
    if (opc >= 8'd32) return 2'd1;
    return 2'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of check input; queue the report if it is expected to reach the consumer.
  task automatic applyStimulus(input logic v, input logic c, input logic [OPW-1:0] opc,
                               input logic fl, input logic expectReport);
    chk_valid  = v;
    chk_cond   = c;
    chk_opcode = opc;
    flush      = fl;
    if (expectReport) sb.push_back({expType(opc), opc});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
  endtask

  // Every accepted report is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && rpt_valid && rpt_ready) begin
      vectors++;
      assert (sb.size() > 0) else begin
        miscompares++;
        $error("[TB] FAIL unexpected_report: observed 0x%0h expected none", {rpt_type, rpt_opcode});
      end
      if (sb.size() > 0) checkOutput("report", 32'({rpt_type, rpt_opcode}), 32'(sb.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; chk_valid = 1'b0; chk_cond = 1'b1; chk_opcode = '0; flush = 1'b0; rpt_ready = 1'b0;
    #2;
    checkOutput("reset_valid", 32'(rpt_valid), 32'd0);
    checkOutput("reset_type", 32'(rpt_type), 32'd0);
    checkOutput("reset_opcode", 32'(rpt_opcode), 32'd0);
    checkOutput("reset_drop", 32'(drop_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // Single fail: two-cycle latency, one-cycle report.
    rpt_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'd10, 1'b0, 1'b1);
    checkOutput("lat_n1_valid", 32'(rpt_valid), 32'd0);
    idle();
    checkOutput("lat_n2_valid", 32'(rpt_valid), 32'd1);
    checkOutput("lat_n2_type", 32'(rpt_type), 32'd0);
    checkOutput("lat_n2_opcode", 32'(rpt_opcode), 32'd10);
    idle();
    checkOutput("lat_n3_valid", 32'(rpt_valid), 32'd0);

    // Back-to-back fails emit on consecutive cycles.
    applyStimulus(1'b1, 1'b0, 8'd40, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'd70, 1'b0, 1'b1);
    checkOutput("b2b_first", 32'({rpt_valid, rpt_type, rpt_opcode}), 32'({1'b1, 2'd1, 8'd40}));
    idle();
    checkOutput("b2b_second", 32'({rpt_valid, rpt_type, rpt_opcode}), 32'({1'b1, 2'd2, 8'd70}));
    idle();
    checkOutput("b2b_done", 32'(rpt_valid), 32'd0);

    // Flush discards the pending 5 but stages the concurrent 6.
    applyStimulus(1'b1, 1'b0, 8'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd6, 1'b1, 1'b1);
    checkOutput("flush_gap", 32'(rpt_valid), 32'd0);
    idle();
    checkOutput("flush_keep", 32'({rpt_valid, rpt_opcode}), 32'({1'b1, 8'd6}));
    idle();
    checkOutput("flush_done", 32'(rpt_valid), 32'd0);

    // Consumer stalled: four queue, two drop, head stays put.
    rpt_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'd1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'd33, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'd65, 1'b0, 1'b1);
    checkOutput("stall_head_early", 32'({rpt_valid, rpt_type, rpt_opcode}), 32'({1'b1, 2'd0, 8'd1}));
    applyStimulus(1'b1, 1'b0, 8'd2, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'd34, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd66, 1'b0, 1'b0);
    idle();
    checkOutput("stall_drop_cnt", 32'(drop_cnt), 32'd2);
    checkOutput("stall_head_late", 32'({rpt_valid, rpt_type, rpt_opcode}), 32'({1'b1, 2'd0, 8'd1}));

    // Full FIFO: push and pop in the same cycle must not drop.
    applyStimulus(1'b1, 1'b0, 8'd20, 1'b0, 1'b1);
    rpt_ready = 1'b1;
    idle();
    rpt_ready = 1'b0;
    checkOutput("full_pp_drop", 32'(drop_cnt), 32'd2);
    checkOutput("full_pp_head", 32'({rpt_valid, rpt_type, rpt_opcode}), 32'({1'b1, 2'd1, 8'd33}));
    rpt_ready = 1'b1;
    for (int i = 0; i < 6; i++) idle();
    checkOutput("full_pp_drained", 32'(rpt_valid), 32'd0);
    checkOutput("full_pp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-operation with three queued and one pending.
    rpt_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd8, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd9, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd11, 1'b0, 1'b0);
    checkOutput("pre_rst_valid", 32'(rpt_valid), 32'd1);
    chk_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", 32'(rpt_valid), 32'd0);
    checkOutput("rst_async_fields", 32'({rpt_type, rpt_opcode}), 32'd0);
    checkOutput("rst_async_drop", 32'(drop_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rpt_ready = 1'b1;
    idle();
    checkOutput("post_rst_valid", 32'(rpt_valid), 32'd0);
    for (int i = 0; i < 5; i++) idle();
    checkOutput("post_rst_quiet", 32'(rpt_valid), 32'd0);

    // First fail after reset follows normal latency.
    applyStimulus(1'b1, 1'b0, 8'd100, 1'b0, 1'b1);
    checkOutput("post_rst_n1", 32'(rpt_valid), 32'd0);
    idle();
    checkOutput("post_rst_n2", 32'({rpt_valid, rpt_type, rpt_opcode}), 32'({1'b1, 2'd2, 8'd100}));
    idle();
    idle();
`ifdef OPCODE_ERR_STATS_EN
    checkOutput("stats_cnt0", 32'(type_cnt0), 32'd0);
    checkOutput("stats_cnt1", 32'(type_cnt1), 32'd0);
    checkOutput("stats_cnt2", 32'(type_cnt2), 32'd1);
`endif
    checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
